// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and constants for the RTC parallel-bus block.
// Holds the bus sequencer state encoding and the RTC register map that the
// upstream control FSM uses to address the chip.
package rtc_pkg;

    // Bus cycle states, in the order the sequencer walks them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        GAP    = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } rtc_state_e;

    // RTC register map on the multiplexed AD bus.
    localparam logic [7:0] RTC_REG_CTRL   = 8'h20;
    localparam logic [7:0] RTC_REG_SEC    = 8'h21;
    localparam logic [7:0] RTC_REG_MIN    = 8'h22;
    localparam logic [7:0] RTC_REG_HOUR   = 8'h23;
    localparam logic [7:0] RTC_REG_DAY    = 8'h24;
    localparam logic [7:0] RTC_REG_MONTH  = 8'h25;
    localparam logic [7:0] RTC_REG_YEAR   = 8'h26;
    localparam logic [7:0] RTC_REG_STATUS = 8'h2F;

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: request-side handshake plus chip-side AD bus signals of
// the RTC bus sequencer. The slave modport is the sequencer's view; the
// master modport is the view of whoever issues requests and models the chip.
// Optional feature macro: RTC_BUS_BCD_CHECK_EN adds the bcd_err flag.
interface rtc_bus_ctrl_if;
    // request side
    logic       wr_req;
    logic       rd_req;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
`ifdef RTC_BUS_BCD_CHECK_EN
    logic       bcd_err;
`endif
    // chip side
    logic       cs_n;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output wr_req, rd_req, addr, wr_data, ad_in,
`ifdef RTC_BUS_BCD_CHECK_EN
        input  bcd_err,
`endif
        input  busy, done, rd_data, rd_valid, cs_n, ale, rd_n, wr_n, ad_out, ad_oe
    );

    modport slave (
        input  wr_req, rd_req, addr, wr_data, ad_in,
`ifdef RTC_BUS_BCD_CHECK_EN
        output bcd_err,
`endif
        output busy, done, rd_data, rd_valid, cs_n, ale, rd_n, wr_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_phase_cnt.sv
// rtc_phase_cnt: counts the cycles of one bus phase. restart zeroes the count
// on phase entry; last is high in the final cycle of a PHASE_CYC-long phase.
// The count saturates at the last value so an idle sequencer leaves it parked.
module rtc_phase_cnt #(
    parameter int PHASE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic last
);
    // A single-cycle phase still needs one bit of counter.
    localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(PHASE_CYC - 1);

    logic [CW-1:0] count_reg;

    // Phase cycle counter, restarted on every phase entry.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count_reg <= '0;
        end else if (count_reg != LAST_VAL) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign last = (count_reg == LAST_VAL);
endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequencer for the RTC chip's multiplexed address/data bus.
// Runs ADDR -> GAP -> STROBE -> HOLD (PHASE_CYC cycles each) then a single
// DONE cycle. Every output is a register loaded from the next-state decode,
// so outputs change on the same edge as the state and never follow inputs
// combinationally.
// Optional feature macro: RTC_BUS_BCD_CHECK_EN adds bcd_err, flagging a read
// whose data has a nibble above 9.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    rtc_bus_ctrl_if.slave    bus
);
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_ADDR   = ADDR;
    localparam logic [2:0] S_GAP    = GAP;
    localparam logic [2:0] S_STROBE = STROBE;
    localparam logic [2:0] S_HOLD   = HOLD;
    localparam logic [2:0] S_DONE   = DONE;

    logic [2:0] state_reg, state_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       write_reg, write_next;

    logic       phase_last;
    logic       phase_restart;

    logic       cs_n_reg, cs_n_next;
    logic       ale_reg, ale_next;
    logic       rd_n_reg, rd_n_next;
    logic       wr_n_reg, wr_n_next;
    logic       ad_oe_reg, ad_oe_next;
    logic [7:0] ad_out_reg, ad_out_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       rd_valid_reg, rd_valid_next;
    logic [7:0] rd_data_reg;

    // Every state change is a phase entry, so the counter restarts there.
    assign phase_restart = (state_next != state_reg);

    rtc_phase_cnt #(
        .PHASE_CYC (PHASE_CYC)
    ) u_phase_cnt (
        .clk     (clk),
        .reset   (reset),
        .restart (phase_restart),
        .last    (phase_last)
    );

    // Next-state decode and request capture; requests only count in IDLE.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        write_next = write_reg;
        case (state_reg)
            S_IDLE: begin
                // Write has priority; a simultaneous read is simply dropped.
                if (bus.wr_req) begin
                    state_next = S_ADDR;
                    write_next = 1'b1;
                    addr_next  = bus.addr;
                    wdata_next = bus.wr_data;
                end else if (bus.rd_req) begin
                    state_next = S_ADDR;
                    write_next = 1'b0;
                    addr_next  = bus.addr;
                    wdata_next = bus.wr_data;
                end
            end
            S_ADDR:   if (phase_last) state_next = S_GAP;
            S_GAP:    if (phase_last) state_next = S_STROBE;
            S_STROBE: if (phase_last) state_next = S_HOLD;
            S_HOLD:   if (phase_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode from the state being entered, so registers line up with it.
    always_comb begin
        cs_n_next     = 1'b1;
        ale_next      = 1'b0;
        rd_n_next     = 1'b1;
        wr_n_next     = 1'b1;
        ad_oe_next    = 1'b0;
        ad_out_next   = 8'h00;
        busy_next     = (state_next != S_IDLE);
        done_next     = (state_next == S_DONE);
        rd_valid_next = (state_next == S_DONE) && !write_next;
        case (state_next)
            S_ADDR: begin
                cs_n_next   = 1'b0;
                ale_next    = 1'b1;
                ad_oe_next  = 1'b1;
                ad_out_next = addr_next;
            end
            S_GAP, S_HOLD: begin
                cs_n_next = 1'b0;
                if (write_next) begin
                    ad_oe_next  = 1'b1;
                    ad_out_next = wdata_next;
                end
            end
            S_STROBE: begin
                cs_n_next = 1'b0;
                if (write_next) begin
                    wr_n_next   = 1'b0;
                    ad_oe_next  = 1'b1;
                    ad_out_next = wdata_next;
                end else begin
                    rd_n_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= 8'h00;
            wdata_reg <= 8'h00;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            write_reg <= write_next;
        end
    end

    // Registered bus strobes and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_reg     <= 1'b1;
            ale_reg      <= 1'b0;
            rd_n_reg     <= 1'b1;
            wr_n_reg     <= 1'b1;
            ad_oe_reg    <= 1'b0;
            ad_out_reg   <= 8'h00;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            cs_n_reg     <= cs_n_next;
            ale_reg      <= ale_next;
            rd_n_reg     <= rd_n_next;
            wr_n_reg     <= wr_n_next;
            ad_oe_reg    <= ad_oe_next;
            ad_out_reg   <= ad_out_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    // Read data is captured on the edge closing the last read-strobe cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= 8'h00;
        end else if (state_reg == S_STROBE && phase_last && !write_reg) begin
            rd_data_reg <= bus.ad_in;
        end
    end

    assign bus.cs_n     = cs_n_reg;
    assign bus.ale      = ale_reg;
    assign bus.rd_n     = rd_n_reg;
    assign bus.wr_n     = wr_n_reg;
    assign bus.ad_oe    = ad_oe_reg;
    assign bus.ad_out   = ad_out_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;

`ifdef RTC_BUS_BCD_CHECK_EN
    logic [1:0] nibble_bad;
    logic       bcd_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nibble
            assign nibble_bad[gi] = (rd_data_reg[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    // BCD flag rides on the rd_valid pulse, judged on the captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_err_reg <= 1'b0;
        end else begin
            bcd_err_reg <= rd_valid_next && (|nibble_bad);
        end
    end

    assign bus.bcd_err = bcd_err_reg;
`endif

endmodule
